// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI-lite widths, response codes and LSU master FSM states.
package axil_pkg;
    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 32;
    typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} axil_resp_e;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} lsu_axil_state_e;
endpackage

// File: rtl/lsu_axil_master.sv
// lsu_axil_master: blocking AXI-lite master turning one LSU load/store into one AXI-lite transaction.
module lsu_axil_master
    import axil_pkg::*;
#(
    parameter int ADDR_W = AXIL_ADDR_W,
    parameter int DATA_W = AXIL_DATA_W,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [STRB_W-1:0] req_wstrb_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o
);
    lsu_axil_state_e   state_q;
    logic              req_ready_q, resp_valid_q, resp_err_q;
    logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic              aw_done_q, w_done_q, aw_done_d, w_done_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, resp_rdata_q;
    logic [STRB_W-1:0] wstrb_q;

    // AW and W finish independently; a channel counts as done from its handshake cycle on
    assign aw_done_d = aw_done_q | (awvalid_q & awready_i);
    assign w_done_d  = w_done_q | (wvalid_q & wready_i);

    always_ff @(posedge clk) begin
        resp_valid_q <= 1'b0;
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid_i && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr_i;
                        wdata_q     <= req_wdata_i;
                        wstrb_q     <= req_wstrb_i;
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
                        awvalid_q   <= req_we_i;
                        wvalid_q    <= req_we_i;
                        arvalid_q   <= !req_we_i;
                        state_q     <= req_we_i ? WR_REQ : RD_ADDR;
                    end
                end
                RD_ADDR: if (arready_i) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= RD_DATA;
                end
                RD_DATA: if (rvalid_i) begin
                    resp_rdata_q <= rdata_i;
                    resp_err_q   <= (rresp_i != OKAY);
                    rready_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                WR_REQ: begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (awready_i) awvalid_q <= 1'b0;
                    if (wready_i) wvalid_q <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: if (bvalid_i) begin
                    resp_err_q   <= (bresp_i != OKAY);
                    bready_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign araddr_o     = addr_q;
    assign arvalid_o    = arvalid_q;
    assign rready_o     = rready_q;
    assign awaddr_o     = addr_q;
    assign awvalid_o    = awvalid_q;
    assign wdata_o      = wdata_q;
    assign wstrb_o      = wstrb_q;
    assign wvalid_o     = wvalid_q;
    assign bready_o     = bready_q;
endmodule

// File: tb/tb_lsu_axil_master.sv
// tb_lsu_axil_master: directed, cycle-exact bench acting as both LSU core and AXI-lite slave.
module tb_lsu_axil_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;
    int pass_cnt = 0;
    int total_cnt = 0;
    int resp_cnt = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    lsu_axil_master dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
        .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready),
        .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
        .wdata_o(wdata), .wstrb_o(wstrb), .wvalid_o(wvalid), .wready_i(wready),
        .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
    );

    always @(negedge clk) begin
        if (resp_valid) resp_cnt++;
        if (arvalid && awvalid) overlap++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL pre_accept_ready: got %b want 1", req_ready); else pass_cnt++;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        tick(); tick();
        total_cnt++; if ({req_ready, arvalid, rready, awvalid, wvalid, bready} !== 6'b0) $display("FAIL reset_handshakes: got %b want 000000", {req_ready, arvalid, rready, awvalid, wvalid, bready}); else pass_cnt++;
        total_cnt++; if ({resp_valid, resp_err, resp_rdata} !== 34'h0) $display("FAIL reset_resp: got %b %b %h want 0 0 0", resp_valid, resp_err, resp_rdata); else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready); else pass_cnt++;
    endtask

    task automatic test_load;
        resp_cnt = 0;
        accept(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        total_cnt++; if ({arvalid, araddr, req_ready} !== {1'b1, 32'h8000_0010, 1'b0}) $display("FAIL load_ar: got %b %h %b want 1 80000010 0", arvalid, araddr, req_ready); else pass_cnt++;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        total_cnt++; if ({arvalid, rready} !== 2'b01) $display("FAIL load_rready: got %b want 01", {arvalid, rready}); else pass_cnt++;
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        total_cnt++; if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) $display("FAIL load_resp: got %b %b %h want 1 0 deadbeef", resp_valid, resp_err, resp_rdata); else pass_cnt++;
        total_cnt++; if ({rready, req_ready} !== 2'b01) $display("FAIL load_idle: got %b want 01", {rready, req_ready}); else pass_cnt++;
        tick();
        total_cnt++; if (resp_cnt !== 1) $display("FAIL load_resp_count: got %0d want 1", resp_cnt); else pass_cnt++;
    endtask

    task automatic test_store_split;
        resp_cnt = 0;
        accept(1'b1, 32'h8000_0004, 32'h1234_5678, 4'b0011);
        total_cnt++; if ({awvalid, wvalid, awaddr, wdata, wstrb} !== {2'b11, 32'h8000_0004, 32'h1234_5678, 4'b0011}) $display("FAIL store_req: got %b%b %h %h %b want 11 80000004 12345678 0011", awvalid, wvalid, awaddr, wdata, wstrb); else pass_cnt++;
        wready = 1'b1;
        tick();
        wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if ({awvalid, wvalid, bready} !== 3'b100) $display("FAIL store_aw_hold%0d: got %b want 100", i, {awvalid, wvalid, bready}); else pass_cnt++;
            if (i < 2) tick();
        end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        total_cnt++; if ({awvalid, wvalid, bready, resp_valid} !== 4'b0010) $display("FAIL store_bready: got %b want 0010", {awvalid, wvalid, bready, resp_valid}); else pass_cnt++;
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        total_cnt++; if ({resp_valid, resp_err, bready, resp_rdata} !== {3'b100, 32'hDEAD_BEEF}) $display("FAIL store_resp: got %b%b%b %h want 100 deadbeef", resp_valid, resp_err, bready, resp_rdata); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (resp_cnt !== 1) $display("FAIL store_resp_count: got %0d want 1", resp_cnt); else pass_cnt++;
    endtask

    task automatic test_read_delayed;
        resp_cnt = 0;
        accept(1'b0, 32'h0000_0ABC, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if ({arvalid, rready, araddr} !== {2'b10, 32'h0000_0ABC}) $display("FAIL dly_ar_stable%0d: got %b%b %h want 10 00000abc", i, arvalid, rready, araddr); else pass_cnt++;
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total_cnt++; if ({arvalid, rready, resp_valid} !== 3'b010) $display("FAIL dly_r_wait%0d: got %b want 010", i, {arvalid, rready, resp_valid}); else pass_cnt++;
            tick();
        end
        rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        total_cnt++; if ({resp_valid, rready, resp_rdata} !== {2'b10, 32'hCAFE_F00D}) $display("FAIL dly_resp: got %b%b %h want 10 cafef00d", resp_valid, rready, resp_rdata); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (resp_cnt !== 1) $display("FAIL dly_resp_count: got %0d want 1", resp_cnt); else pass_cnt++;
    endtask

    task automatic test_errors;
        accept(1'b1, 32'h9000_0000, 32'hA5A5_A5A5, 4'hF);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        total_cnt++; if ({awvalid, wvalid, bready} !== 3'b001) $display("FAIL err_wr_bready: got %b want 001", {awvalid, wvalid, bready}); else pass_cnt++;
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        total_cnt++; if ({resp_valid, resp_err, req_ready, bready} !== 4'b1110) $display("FAIL err_slverr: got %b want 1110", {resp_valid, resp_err, req_ready, bready}); else pass_cnt++;
        accept(1'b0, 32'hF000_0000, 32'h0, 4'h0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h1111_2222; rresp = 2'b11;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        total_cnt++; if ({resp_valid, resp_err, req_ready, resp_rdata} !== {3'b111, 32'h1111_2222}) $display("FAIL err_decerr: got %b%b%b %h want 111 11112222", resp_valid, resp_err, req_ready, resp_rdata); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back;
        resp_cnt = 0; overlap = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0100;
        tick();
        req_we = 1'b1; req_addr = 32'h0000_0200; req_wdata = 32'h0BAD_F00D; req_wstrb = 4'hF;
        total_cnt++; if ({arvalid, araddr} !== {1'b1, 32'h0000_0100}) $display("FAIL b2b_ar1: got %b %h want 1 00000100", arvalid, araddr); else pass_cnt++;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_1111;
        tick();
        rvalid = 1'b0;
        total_cnt++; if ({resp_valid, req_ready, resp_rdata} !== {2'b11, 32'h0000_1111}) $display("FAIL b2b_resp1: got %b%b %h want 11 00001111", resp_valid, req_ready, resp_rdata); else pass_cnt++;
        tick();
        total_cnt++; if ({awvalid, wvalid, arvalid, awaddr, wdata} !== {3'b110, 32'h0000_0200, 32'h0BAD_F00D}) $display("FAIL b2b_aw: got %b%b%b %h %h want 110 00000200 0badf00d", awvalid, wvalid, arvalid, awaddr, wdata); else pass_cnt++;
        req_we = 1'b0; req_addr = 32'h0000_0300;
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        total_cnt++; if ({resp_valid, req_ready, resp_err} !== 3'b110) $display("FAIL b2b_resp2: got %b want 110", {resp_valid, req_ready, resp_err}); else pass_cnt++;
        tick();
        req_valid = 1'b0;
        total_cnt++; if ({arvalid, awvalid, araddr} !== {2'b10, 32'h0000_0300}) $display("FAIL b2b_ar3: got %b%b %h want 10 00000300", arvalid, awvalid, araddr); else pass_cnt++;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_3333;
        tick();
        rvalid = 1'b0;
        total_cnt++; if ({resp_valid, resp_rdata} !== {1'b1, 32'h0000_3333}) $display("FAIL b2b_resp3: got %b %h want 1 00003333", resp_valid, resp_rdata); else pass_cnt++;
        tick(); tick();
        total_cnt++; if ({resp_cnt, overlap} !== {32'd3, 32'd0}) $display("FAIL b2b_counts: got resp=%0d overlap=%0d want 3 0", resp_cnt, overlap); else pass_cnt++;
    endtask

    task automatic test_rst_abort;
        resp_cnt = 0;
        accept(1'b0, 32'h4000_0000, 32'h0, 4'h0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        total_cnt++; if (rready !== 1'b1) $display("FAIL abort_in_rdata: got %b want 1", rready); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++; if ({req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid} !== 7'b0) $display("FAIL abort_cleared: got %b want 0000000", {req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid}); else pass_cnt++;
        rvalid = 1'b1; rdata = 32'hBADB_AD00;
        tick();
        rvalid = 1'b0;
        total_cnt++; if ({rready, resp_valid, req_ready} !== 3'b001) $display("FAIL abort_late_rvalid: got %b want 001", {rready, resp_valid, req_ready}); else pass_cnt++;
        tick();
        total_cnt++; if ({resp_cnt, resp_rdata} !== {32'd0, 32'h0}) $display("FAIL abort_no_resp: got cnt=%0d rdata=%h want 0 0", resp_cnt, resp_rdata); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_split();
        test_read_delayed();
        test_errors();
        test_back_to_back();
        test_rst_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
